// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
// Buffers (a, b) operand pairs in a small FIFO, launches each pair into
// seq_mul with a one-cycle start pulse, waits the multiplier latency,
// captures the product and holds it on a valid/ready output port.
// Only one multiply is ever in flight.

module mul_issue_ctrl #(
    parameter int W       = 4,
    parameter int MUL_LAT = 4,
    parameter int DEPTH   = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,

    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   in_a_i,
    input  logic [W-1:0]   in_b_i,

    output logic           mul_start_o,
    output logic [W-1:0]   mul_a_o,
    output logic [W-1:0]   mul_b_o,
    input  logic [2*W-1:0] mul_op_i,

    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*W-1:0] out_p_o,
    output logic [W-1:0]   out_a_o,
    output logic [W-1:0]   out_b_o,
    output logic [7:0]     done_cnt_o
);

    // DEPTH is a power of two, so the pointers wrap for free.
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Operand FIFO storage and bookkeeping
    logic [W-1:0]     fifoA_q [DEPTH];
    logic [W-1:0]     fifoB_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             pop;
    logic [W-1:0]     headA;
    logic [W-1:0]     headB;

    // Sequencer and result registers
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              outValid_q, outValid_d;
    logic [2*W-1:0]    outP_q, outP_d;
    logic [W-1:0]      outA_q, outA_d;
    logic [W-1:0]      outB_q, outB_d;
    logic [7:0]        doneCnt_q, doneCnt_d;

    logic              issuing;

    assign fifoFull  = (count_q == CNT_W'(DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign headA     = fifoA_q[rdPtr_q];
    assign headB     = fifoB_q[rdPtr_q];

    // Ready depends only on the registered count, never on the same-cycle pop.
    assign in_ready_o = !fifoFull;
    assign push       = in_valid_i && in_ready_o;

    assign issuing     = (state_q == ISSUE);
    assign mul_start_o = issuing;
    assign mul_a_o     = issuing ? headA : '0;
    assign mul_b_o     = issuing ? headB : '0;

    assign out_valid_o = outValid_q;
    assign out_p_o     = outP_q;
    assign out_a_o     = outA_q;
    assign out_b_o     = outB_q;
    assign done_cnt_o  = doneCnt_q;

    // FIFO pointer and occupancy update; push and pop together keep the count.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write on accepted input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifoA_q[i] <= '0;
                fifoB_q[i] <= '0;
            end
        end else if (push) begin
            fifoA_q[wrPtr_q] <= in_a_i;
            fifoB_q[wrPtr_q] <= in_b_i;
        end
    end

    // FIFO pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Issue/wait/hold sequencer: next state, pop, and result register updates.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        outValid_d = outValid_q;
        outP_d     = outP_q;
        outA_d     = outA_q;
        outB_d     = outB_q;
        doneCnt_d  = doneCnt_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                pop       = !fifoEmpty;
                outA_d    = headA;
                outB_d    = headB;
                waitCnt_d = WAIT_W'(MUL_LAT);
                state_d   = WAIT;
            end

            WAIT: begin
                if (waitCnt_q != '0) begin
                    waitCnt_d = waitCnt_q - WAIT_W'(1);
                end else begin
                    outP_d     = mul_op_i;
                    outValid_d = 1'b1;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                if (out_ready_i) begin
                    doneCnt_d  = doneCnt_q + 8'd1;
                    outValid_d = 1'b0;
                    state_d    = fifoEmpty ? IDLE : ISSUE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and result registers; reset drops any in-flight result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            outValid_q <= 1'b0;
            outP_q     <= '0;
            outA_q     <= '0;
            outB_q     <= '0;
            doneCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            outValid_q <= outValid_d;
            outP_q     <= outP_d;
            outA_q     <= outA_d;
            outB_q     <= outB_d;
            doneCnt_q  <= doneCnt_d;
        end
    end

`ifndef SYNTHESIS
    // The start pulse is always followed by at least one quiet cycle.
    startIsPulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mul_start_o |=> !mul_start_o);

    // ISSUE is only ever entered with something to pop.
    issueHasData: assert property (@(posedge clk_i) disable iff (!rst_ni)
        issuing |-> !fifoEmpty);

    // A held result stays put until it is taken.
    holdIsStable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_p_o)
                                           && $stable(out_a_o) && $stable(out_b_o)));
`endif

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Operand issue and result capture stage wrapped around `seq_mul`. It accepts (a, b) operand pairs on a valid/ready input port and buffers them in a small FIFO. It launches each pair into `seq_mul` with a one-cycle `start` pulse, waits the multiplier's fixed latency, captures `op`, and presents the product with its operands on a valid/ready output port. It sits directly upstream of `seq_mul` and also consumes its product, so the rest of the design never drives `start` or times `op` directly.

## Interface
- `W`, default 4: operand width. Product width is 2W.
- `MUL_LAT`, default 4: number of clock edges after the edge that samples `mul_start` before `mul_op` holds the final product.
- `DEPTH`, default 2: input FIFO depth. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_a`, `in_b`  in  W  operands.
- `mul_start`  out  1  one-cycle start pulse to `seq_mul`.
- `mul_a`, `mul_b`  out  W  operands to `seq_mul`; nonzero only while `mul_start` = 1.
- `mul_op`  in  2W  product from `seq_mul`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream accepts.
- `out_p`  out  2W  product.
- `out_a`, `out_b`  out  W  operands that produced `out_p`.
- `done_cnt`  out  8  count of completed output handshakes; wraps 255 → 0.

## Operation
- FIFO:
  - Push on `in_valid & in_ready`. Pop in ISSUE.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full; no pop when empty.
  - `in_ready` is combinational from the registered count only; there is no bypass.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, go to ISSUE; otherwise stay.
  - ISSUE (exactly 1 cycle):
    - `mul_start` = 1; `mul_a`/`mul_b` = FIFO head.
    - Pop the head; latch it into `out_a`/`out_b`.
    - Load `wait_cnt` = MUL_LAT; go to WAIT.
  - WAIT:
    - While `wait_cnt` ≠ 0, decrement it.
    - When `wait_cnt` = 0, capture `mul_op` into `out_p`, set `out_valid`, go to HOLD.
    - WAIT therefore lasts MUL_LAT+1 cycles.
  - HOLD: `out_valid` = 1; `out_p`, `out_a`, `out_b` stable. On `out_ready`:
    - increment `done_cnt`;
    - clear `out_valid`;
    - go to ISSUE if the FIFO is non-empty, else IDLE.
- Only one multiply is outstanding at a time. `mul_op` is ignored outside the capture cycle.
- Arithmetic:
  - The product is taken from `seq_mul` unmodified (unsigned, 2W bits).
  - `done_cnt` is a modulo-256 counter.
- Reset (asynchronous assert, synchronous-release use):
  - State → IDLE; FIFO emptied.
  - `mul_start`, `mul_a`, `mul_b`, `out_valid`, `out_p`, `out_a`, `out_b`, `done_cnt` all go to 0.
  - `in_ready` = 1.
- Reset mid-ISSUE/WAIT/HOLD: the in-flight result is discarded and never presented. `seq_mul` may keep computing; its output is harmless because the next ISSUE restarts it.

## Timing
- Accept at edge T:
  - ISSUE occupies cycle [T+1, T+2]; `seq_mul` samples `mul_start` at edge T+2.
  - `out_p` is captured at edge T+MUL_LAT+3; `out_valid` is high from then on. Default: 7 edges.
- Output handshake at edge H with the FIFO non-empty: the next ISSUE occupies [H, H+1].
  - Steady-state throughput: one result per MUL_LAT+3 cycles with `out_ready` held at 1.
- `mul_start` is never high in two consecutive cycles. `mul_a`/`mul_b` are 0 whenever `mul_start` = 0.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → all outputs 0, `in_ready` = 1, no `mul_start` pulse. Release → outputs stay idle until `in_valid`.
- Single op (with `seq_mul` attached), a=4'b0101, b=4'b1001, `out_ready` = 1:
  - `mul_start` pulses once with `mul_a`=5, `mul_b`=9 in the cycle after accept+1.
  - `out_valid` rises 7 edges after accept with `out_p`=8'h2D, `out_a`=5, `out_b`=9.
  - `done_cnt` = 1 after the handshake.
- Back-to-back: push (13,5), (15,15), (0,7) on consecutive cycles, `out_ready` = 1.
  - `in_ready` drops for exactly one cycle, so the third push lands one cycle late.
  - Results arrive in order: 8'h41, 8'hE1, 8'h00, spaced 7 cycles apart.
- Backpressure: hold `out_ready` = 0 for 20 cycles with 3 ops queued.
  - `out_p`=8'h41 stays stable; no further `mul_start` pulses.
  - FIFO fills and `in_ready` = 0.
  - Release `out_ready` → remaining results drain in order.
- Reset mid-WAIT: assert `rst_n` = 0 at 2 edges after `mul_start`.
  - `out_valid` never rises and `done_cnt` = 0.
  - The queued op is lost.
  - The next new input produces a correct product.
- Counter wrap: 256 ops with random operands, each checked against a×b → `done_cnt` reads 255 after 255 handshakes and 0 after 256.
